// File: rtl/term_cmd_decoder_pkg.sv
// Shared constants and types for the terminal command decoder: write types,
// ASCII control codes, geometry defaults and FSM encodings.
package term_pkg;
    localparam logic [1:0] DT_CHAR = 2'd0;
    localparam logic [1:0] DT_COL  = 2'd1;
    localparam logic [1:0] DT_ROW  = 2'd2;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_Y     = 8'h59;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam int ROWS_DEF    = 30;
    localparam int COLS_DEF    = 80;
    localparam int CLEAR_COUNT = ROWS_DEF * COLS_DEF;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ESC, ST_ESC_ROW, ST_ESC_COL,
        ST_SETUP, ST_STB_HI, ST_STB_LO, ST_CLEAR
    } dec_state_t;

    typedef enum logic [1:0] {SG_IDLE, SG_SETUP, SG_HI, SG_LO} stb_state_t;

    // VT52 coordinate: byte minus 0x20, clamped to [0, lim].
    function automatic logic [7:0] addr_coord(input logic [7:0] b, input logic [7:0] lim);
        logic [7:0] d;
        d = b - CH_SPACE;
        if (b < CH_SPACE) d = 8'd0;
        if (d > lim) d = lim;
        return d;
    endfunction
endpackage

// File: rtl/term_cmd_decoder_strobe_gen.sv
// Single-transaction write engine: latches {dtype,data} on request, then
// runs one setup cycle, STROBE_HIGH cycles of dstrobe high and STROBE_LOW low.
module term_strobe_gen
    import term_pkg::*;
#(
    parameter int STROBE_HIGH = 8,
    parameter int STROBE_LOW  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] req_dtype,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe,
    output logic       lo_phase,
    output logic       last
);
    stb_state_t st;
    logic [7:0] cnt;

    assign ack      = (st == SG_IDLE) && req;
    assign lo_phase = (st == SG_LO);
    // Final low cycle: lets the sequencer launch the next step on the same edge.
    assign last     = lo_phase && (cnt == 8'(STROBE_LOW - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= SG_IDLE;
            cnt     <= 8'd0;
            data    <= 8'd0;
            dtype   <= DT_CHAR;
            dstrobe <= 1'b0;
        end else begin
            case (st)
                SG_IDLE: if (req) begin
                    data  <= req_data;
                    dtype <= req_dtype;
                    st    <= SG_SETUP;
                end
                SG_SETUP: begin
                    dstrobe <= 1'b1;
                    cnt     <= 8'd0;
                    st      <= SG_HI;
                end
                SG_HI: if (cnt == 8'(STROBE_HIGH - 1)) begin
                    dstrobe <= 1'b0;
                    cnt     <= 8'd0;
                    st      <= SG_LO;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                SG_LO: if (last) begin
                    cnt <= 8'd0;
                    st  <= SG_IDLE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: st <= SG_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/term_cmd_decoder.sv
// Byte-stream decoder for the character terminal: control codes, VT52 ESC Y
// cursor addressing and screen clear, sequenced into the strobe generator.
module term_cmd_decoder
    import term_pkg::*;
#(
    parameter int STROBE_HIGH = 8,
    parameter int STROBE_LOW  = 8,
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] currow,
    input  logic [6:0] curcol,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe,
    output logic       busy
);
    localparam int CLR_N = ROWS * COLS;

    dec_state_t state;
    logic       req, ack, lo_phase, last;
    logic [1:0] req_dtype;
    logic [7:0] req_data;
    logic       col_pend, clr_mode;
    logic [7:0] pend_col, esc_row;
    logic [2:0] clr_phase;
    logic [11:0] clr_cnt;

    logic       idle_go;
    logic [1:0] idle_dtype;
    logic [7:0] idle_data, lf_row, bs_col, tab_raw, tab_col;

    assign in_ready = state inside {ST_IDLE, ST_ESC, ST_ESC_ROW, ST_ESC_COL};
    assign busy     = !(state inside {ST_IDLE, ST_ESC, ST_ESC_ROW});

    assign lf_row  = (currow == 5'(ROWS - 1)) ? 8'd0 : {3'b0, currow} + 8'd1;
    assign bs_col  = {1'b0, curcol} - 8'd1;
    assign tab_raw = {1'b0, curcol | 7'd7} + 8'd1;
    assign tab_col = (tab_raw > 8'(COLS - 1)) ? 8'(COLS - 1) : tab_raw;

    // Single-transaction bytes decoded in IDLE; ESC and FF are handled in the FSM.
    always_comb begin
        idle_go    = 1'b0;
        idle_dtype = DT_CHAR;
        idle_data  = in_data;
        case (in_data)
            CH_CR:  begin idle_go = 1'b1; idle_dtype = DT_COL; idle_data = 8'd0; end
            CH_LF:  begin idle_go = 1'b1; idle_dtype = DT_ROW; idle_data = lf_row; end
            CH_BS:  begin idle_go = (curcol != 7'd0); idle_dtype = DT_COL; idle_data = bs_col; end
            CH_TAB: begin idle_go = 1'b1; idle_dtype = DT_COL; idle_data = tab_col; end
            default: idle_go = (in_data >= CH_SPACE) && (in_data != CH_DEL);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req       <= 1'b0;
            req_dtype <= DT_CHAR;
            req_data  <= 8'd0;
            col_pend  <= 1'b0;
            pend_col  <= 8'd0;
            esc_row   <= 8'd0;
            clr_mode  <= 1'b0;
            clr_phase <= 3'd0;
            clr_cnt   <= 12'd0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    if (in_data == CH_ESC) begin
                        state <= ST_ESC;
                    end else if (in_data == CH_FF) begin
                        clr_mode  <= 1'b1;
                        clr_phase <= 3'd0;
                        clr_cnt   <= 12'd0;
                        state     <= ST_CLEAR;
                    end else if (idle_go) begin
                        req       <= 1'b1;
                        req_dtype <= idle_dtype;
                        req_data  <= idle_data;
                        state     <= ST_SETUP;
                    end
                end
                ST_ESC: if (in_valid) state <= (in_data == CH_Y) ? ST_ESC_ROW : ST_IDLE;
                ST_ESC_ROW: if (in_valid) begin
                    esc_row <= addr_coord(in_data, 8'(ROWS - 1));
                    state   <= ST_ESC_COL;
                end
                ST_ESC_COL: if (in_valid) begin
                    req       <= 1'b1;
                    req_dtype <= DT_ROW;
                    req_data  <= esc_row;
                    pend_col  <= addr_coord(in_data, 8'(COLS - 1));
                    col_pend  <= 1'b1;
                    state     <= ST_SETUP;
                end
                ST_SETUP: if (ack) begin
                    req   <= 1'b0;
                    state <= ST_STB_HI;
                end
                ST_STB_HI: if (lo_phase) state <= ST_STB_LO;
                ST_STB_LO: if (last) begin
                    if (col_pend) begin
                        col_pend  <= 1'b0;
                        req       <= 1'b1;
                        req_dtype <= DT_COL;
                        req_data  <= pend_col;
                        state     <= ST_SETUP;
                    end else if (clr_mode && clr_phase != 3'd5) begin
                        state <= ST_CLEAR;
                    end else begin
                        clr_mode <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // Home, blank every cell, then home again.
                    req   <= 1'b1;
                    state <= ST_SETUP;
                    case (clr_phase)
                        3'd0: begin req_dtype <= DT_ROW; req_data <= 8'd0; clr_phase <= 3'd1; end
                        3'd1: begin req_dtype <= DT_COL; req_data <= 8'd0; clr_phase <= 3'd2; end
                        3'd2: begin
                            req_dtype <= DT_CHAR;
                            req_data  <= CH_SPACE;
                            if (clr_cnt == 12'(CLR_N - 1)) clr_phase <= 3'd3;
                            else clr_cnt <= clr_cnt + 12'd1;
                        end
                        3'd3: begin req_dtype <= DT_ROW; req_data <= 8'd0; clr_phase <= 3'd4; end
                        default: begin req_dtype <= DT_COL; req_data <= 8'd0; clr_phase <= 3'd5; end
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    term_strobe_gen #(.STROBE_HIGH(STROBE_HIGH), .STROBE_LOW(STROBE_LOW)) u_stb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_dtype (req_dtype),
        .req_data  (req_data),
        .ack       (ack),
        .data      (data),
        .dtype     (dtype),
        .dstrobe   (dstrobe),
        .lo_phase  (lo_phase),
        .last      (last)
    );
endmodule

// File: tb/tb_term_cmd_decoder.sv
// Scoreboard bench for term_cmd_decoder: expected {dtype,data} writes are
// queued as bytes are sent and matched against each dstrobe rising edge.
module tb_term_cmd_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] currow = 5'd0;
    logic [6:0] curcol = 7'd0;
    logic [7:0] data;
    logic [1:0] dtype;
    logic       dstrobe;
    logic       busy;

    int nchecks = 0;
    int nerr = 0;
    int pulse_cnt = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    term_cmd_decoder dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .currow(currow), .curcol(curcol), .data(data),
        .dtype(dtype), .dstrobe(dstrobe), .busy(busy)
    );

    // Pulse monitor: compare each write to the scoreboard, check high width.
    initial begin : monitor
        logic       prev_stb;
        int         hi_cnt;
        logic [9:0] exp;
        prev_stb = 1'b0;
        hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stb = 1'b0;
                hi_cnt = 0;
            end else begin
                if (dstrobe && !prev_stb) begin
                    pulse_cnt++;
                    nchecks++;
                    hi_cnt = 0;
                    if (exp_q.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_pulse: got dtype=%0d data=%02h, none expected", dtype, data);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({dtype, data} !== exp) begin
                            nerr++;
                            $display("FAIL pulse_%0d: got dtype=%0d data=%02h, expected dtype=%0d data=%02h",
                                     pulse_cnt, dtype, data, exp[9:8], exp[7:0]);
                        end
                    end
                end
                if (dstrobe) hi_cnt++;
                if (!dstrobe && prev_stb) begin
                    nchecks++;
                    if (hi_cnt !== 8) begin
                        nerr++;
                        $display("FAIL strobe_width: got %0d cycles, expected 8", hi_cnt);
                    end
                end
                prev_stb = dstrobe;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nchecks++; nerr++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
        end
        in_data = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while ((!in_ready || busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready || busy) begin
            nchecks++; nerr++;
            $display("FAIL idle_timeout: busy=%0b in_ready=%0b, expected 0/1", busy, in_ready);
        end
        repeat (3) @(negedge clk);
        nchecks++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL pending_pulses: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchecks++;
        if ({data, dtype, dstrobe, busy, in_ready} !== {8'h00, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset_values: got data=%02h dtype=%0d stb=%0b busy=%0b rdy=%0b, expected 00/0/0/0/1",
                     data, dtype, dstrobe, busy, in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_char();
        int rdy_hi = 0;
        int hi = 0;
        exp_q.push_back({2'd0, 8'h41});
        send_byte(8'h41);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
            if (dstrobe) hi++;
            if (k == 2) begin
                nchecks++;
                if ({dtype, data, dstrobe} !== {2'd0, 8'h41, 1'b0}) begin
                    nerr++;
                    $display("FAIL char_setup: got dtype=%0d data=%02h stb=%0b, expected 0/41/0", dtype, data, dstrobe);
                end
            end
        end
        nchecks++;
        if (rdy_hi !== 0) begin nerr++; $display("FAIL char_ready_low: got %0d ready cycles, expected 0", rdy_hi); end
        nchecks++;
        if (hi !== 8) begin nerr++; $display("FAIL char_high_cycles: got %0d, expected 8", hi); end
        @(negedge clk);
        nchecks++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL char_ready_return: got %0b, expected 1", in_ready); end
        wait_idle(50);
    endtask

    task automatic test_cr_bs();
        int base;
        int rdy_lo = 0;
        curcol = 7'd37;
        exp_q.push_back({2'd1, 8'd0});
        send_byte(8'h0D);
        wait_idle(100);
        base = pulse_cnt;
        curcol = 7'd0;
        send_byte(8'h08);
        repeat (20) begin
            @(negedge clk);
            if (!in_ready) rdy_lo++;
        end
        nchecks++;
        if (rdy_lo !== 0) begin nerr++; $display("FAIL bs_ready: got %0d low cycles, expected 0", rdy_lo); end
        nchecks++;
        if (pulse_cnt !== base) begin nerr++; $display("FAIL bs_no_pulse: got %0d pulses, expected 0", pulse_cnt - base); end
        curcol = 7'd10;
        exp_q.push_back({2'd1, 8'd9});
        send_byte(8'h08);
        wait_idle(100);
    endtask

    task automatic test_lf_tab();
        logic [9:0] vec[4];
        logic [7:0] byt[4];
        logic [6:0] col[4];
        logic [4:0] row[4];
        vec = '{{2'd2, 8'd0}, {2'd2, 8'd13}, {2'd1, 8'd40}, {2'd1, 8'd79}};
        byt = '{8'h0A, 8'h0A, 8'h09, 8'h09};
        row = '{5'd29, 5'd12, 5'd0, 5'd0};
        col = '{7'd0, 7'd0, 7'd37, 7'd78};
        for (int i = 0; i < 4; i++) begin
            currow = row[i];
            curcol = col[i];
            exp_q.push_back(vec[i]);
            send_byte(byt[i]);
            wait_idle(100);
        end
    endtask

    task automatic test_esc();
        int base;
        exp_q.push_back({2'd2, 8'd5});
        exp_q.push_back({2'd1, 8'd16});
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h25); send_byte(8'h30);
        wait_idle(200);
        exp_q.push_back({2'd2, 8'd29});
        exp_q.push_back({2'd1, 8'd79});
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h7F); send_byte(8'h7F);
        wait_idle(200);
        exp_q.push_back({2'd2, 8'd0});
        exp_q.push_back({2'd1, 8'd1});
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h10); send_byte(8'h21);
        wait_idle(200);
        base = pulse_cnt;
        send_byte(8'h1B); send_byte(8'h51);
        repeat (20) @(negedge clk);
        nchecks++;
        if (pulse_cnt !== base || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL esc_discard: got %0d pulses rdy=%0b, expected 0 pulses rdy=1", pulse_cnt - base, in_ready);
        end
        exp_q.push_back({2'd0, 8'h43});
        send_byte(8'h43);
        wait_idle(100);
    endtask

    task automatic test_clear();
        int base;
        int rdy_hi = 0;
        int n = 0;
        base = pulse_cnt;
        exp_q.push_back({2'd2, 8'd0});
        exp_q.push_back({2'd1, 8'd0});
        for (int i = 0; i < 2400; i++) exp_q.push_back({2'd0, 8'h20});
        exp_q.push_back({2'd2, 8'd0});
        exp_q.push_back({2'd1, 8'd0});
        send_byte(8'h0C);
        @(negedge clk);
        nchecks++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL clear_busy_start: got %0b, expected 1", busy); end
        while (busy && n < 60000) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
            n++;
        end
        nchecks++;
        if (busy) begin nerr++; $display("FAIL clear_timeout: busy=1 after %0d cycles, expected 0", n); end
        nchecks++;
        if (rdy_hi !== 0) begin nerr++; $display("FAIL clear_ready: got %0d ready cycles, expected 0", rdy_hi); end
        nchecks++;
        if (pulse_cnt - base !== 2404) begin nerr++; $display("FAIL clear_pulses: got %0d, expected 2404", pulse_cnt - base); end
        wait_idle(50);
    endtask

    task automatic test_reset_mid();
        int base;
        int n = 0;
        base = pulse_cnt;
        exp_q.push_back({2'd2, 8'd0});
        exp_q.push_back({2'd1, 8'd0});
        for (int i = 0; i < 998; i++) exp_q.push_back({2'd0, 8'h20});
        send_byte(8'h0C);
        while (pulse_cnt < base + 1000 && n < 30000) begin
            @(posedge clk);
            #1 n++;
        end
        nchecks++;
        if (dstrobe !== 1'b1 || pulse_cnt !== base + 1000) begin
            nerr++;
            $display("FAIL mid_clear_reach: got stb=%0b pulses=%0d, expected 1/1000", dstrobe, pulse_cnt - base);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        nchecks++;
        if ({dstrobe, busy, in_ready} !== 3'b001) begin
            nerr++;
            $display("FAIL mid_reset: got stb=%0b busy=%0b rdy=%0b, expected 0/0/1", dstrobe, busy, in_ready);
        end
        exp_q.delete();
        exp_q.push_back({2'd0, 8'h42});
        send_byte(8'h42);
        wait_idle(100);
    endtask

    initial begin
        test_reset();
        test_char();
        test_cr_bs();
        test_lf_tab();
        test_esc();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
